axi4lite_regfile_slave: RTL

//   AXI4-Lite responder holding a small register file for the 2-bit-address, 8-bit-data
//   AXI4-Lite link that the on-chip master drives. It accepts AW and W independently, in

---
 rtl/axi4lite_regfile_slave_if.sv | 39 +++
 rtl/axi4lite_regfile_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for the small register-file responder.
// The master modport is the on-chip initiator; the slave modport is the register file.
interface axi4lite_regfile_slave_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
);
  // Write address channel
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  // Write data channel
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic              wvalid;
  logic              wready;
  // Write response channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // Read address channel
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  // Read data channel
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file: registers 0..N-2 are read/write and exported on regs_o,
// the top address reads the external status byte and rejects writes with SLVERR.
// AW and W are latched independently; the write commits one edge after both are held.
module axi4lite_regfile_slave #(
  parameter int unsigned       ADDR_W    = 2,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                                s_axi_aclk,
  input  logic                                s_axi_aresetn,
  axi4lite_regfile_slave_if.slave             s_axi,
  input  logic [DATA_W-1:0]                   status_i,
  output logic [((2**ADDR_W)-1)*DATA_W-1:0]   regs_o
);

  localparam int unsigned       NREG        = 2**ADDR_W;
  localparam int unsigned       NRW         = NREG - 1;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = '1;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HOLD,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rd_state_t;

  // Write channel state
  wr_state_t         wr_state_q;
  logic              aw_held_q;
  logic              w_held_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_strb_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  // Read channel state
  rd_state_t         rd_state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // Register storage
  logic [DATA_W-1:0] regs_q [NRW];

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [DATA_W-1:0] rd_mux;

  assign aw_hs  = s_axi.awvalid & awready_q;
  assign w_hs   = s_axi.wvalid  & wready_q;
  assign ar_hs  = s_axi.arvalid & arready_q;
  assign commit = (wr_state_q == WR_HOLD) & aw_held_q & w_held_q;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  // Write FSM: latch AW and W in any order, commit once both are held, then hold B until accepted
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE, WR_HOLD: begin
          if (commit) begin
            // Both halves held, so both readys are already low and no new handshake can land here.
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= (wr_addr_q == STATUS_ADDR) ? RESP_SLVERR : RESP_OKAY;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_state_q <= WR_RESP;
          end else begin
            if (aw_hs) begin
              wr_addr_q <= s_axi.awaddr;
              aw_held_q <= 1'b1;
            end
            if (w_hs) begin
              wr_data_q <= s_axi.wdata;
              wr_strb_q <= s_axi.wstrb;
              w_held_q  <= 1'b1;
            end
            awready_q <= ~(aw_held_q | aw_hs);
            wready_q  <= ~(w_held_q | w_hs);
            if (aw_hs | w_hs | aw_held_q | w_held_q) begin
              wr_state_q <= WR_HOLD;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_IDLE;
          end
        end
        default: begin
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Register file update on write commit; strobe low or status address leaves contents alone
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int unsigned i = 0; i < NRW; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (commit && wr_strb_q) begin
      for (int unsigned i = 0; i < NRW; i++) begin
        if (wr_addr_q == ADDR_W'(i)) begin
          regs_q[i] <= wr_data_q;
        end
      end
    end
  end

  // Read source select: register contents, or the live status byte at the top address
  always_comb begin
    rd_mux = status_i;
    for (int unsigned i = 0; i < NRW; i++) begin
      if (s_axi.araddr == ADDR_W'(i)) begin
        rd_mux = regs_q[i];
      end
    end
  end

  // Read FSM: one sampled response per AR, held until the master accepts it
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_q    <= rd_mux;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= RD_VALID;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RD_VALID: begin
          if (s_axi.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: begin
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

  // Export the R/W registers as a flat vector, register 0 in the low bits
  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NRW; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule
